// File: rtl/out_trace_buffer.sv
// Change-only trace FIFO for a core output bus; entries are {timestamp, sample}.
// Define OUT_TRACE_TS_EN to build the timestamp counter and per-entry TS storage.
module out_trace_buffer #(
    parameter int unsigned DATA_W = 10,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned TS_W   = 16
) (
    input  logic                     CLK,
    input  logic                     reset_n,
    input  logic [DATA_W-1:0]        sample_in,
    input  logic                     sample_en,
    input  logic                     clr_ovf,
    input  logic                     rd_ready,
    output logic                     rd_valid,
    output logic [DATA_W-1:0]        rd_data,
    output logic [TS_W-1:0]          rd_ts,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [AW-1:0]     head_q, head_d;
    logic [AW-1:0]     tail_q, tail_d;
    logic [CW-1:0]     count_q, count_d;
    logic              ovf_q, ovf_d;
    logic [DATA_W-1:0] last_q, last_d;
    logic              arm_q, arm_d;
    logic [DATA_W-1:0] mem_data [DEPTH];

    logic push, pop, full, wr_en, drop;

    always_comb begin
        full  = (count_q == CW'(DEPTH));
        push  = sample_en && (arm_q || (sample_in != last_q));
        pop   = (count_q != '0) && rd_ready;
        // A full FIFO still accepts a push when the head leaves in the same cycle.
        wr_en = push && (!full || pop);
        drop  = push && full && !pop;
    end

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        last_d  = last_q;
        arm_d   = arm_q;
        if (pop) begin
            head_d = head_q + AW'(1);
        end
        if (wr_en) begin
            tail_d = tail_q + AW'(1);
            last_d = sample_in;
            arm_d  = 1'b0;
        end else if (!sample_en) begin
            arm_d = 1'b1;
        end
        if (wr_en && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !wr_en) begin
            count_d = count_q - CW'(1);
        end
        if (drop) begin
            ovf_d = 1'b1;
        end else if (clr_ovf) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            last_q  <= '0;
            arm_q   <= 1'b1;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            last_q  <= last_d;
            arm_q   <= arm_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (wr_en) begin
            mem_data[tail_q] <= sample_in;
        end
    end

`ifdef OUT_TRACE_TS_EN
    logic [TS_W-1:0] ts_q;
    logic [TS_W-1:0] mem_ts [DEPTH];

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            ts_q <= '0;
        end else begin
            ts_q <= ts_q + TS_W'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (wr_en) begin
            mem_ts[tail_q] <= ts_q;
        end
    end

    assign rd_ts = mem_ts[head_q];
`else
    assign rd_ts = '0;
`endif

    assign rd_valid = (count_q != '0);
    assign rd_data  = mem_data[head_q];
    assign count    = count_q;
    assign overflow = ovf_q;

endmodule

// File: doc/out_trace_buffer.md
OUT_TRACE_BUFFER -- requirements
Module: out_trace_buffer

Interface
REQ-001 SHALL have parameter DATA_W, default 10, width of the traced core output bus.
REQ-002 SHALL have parameter DEPTH, default 16, number of FIFO entries, power of two, minimum 2.
REQ-003 SHALL have parameter TS_W, default 16, width of the timestamp counter.
REQ-004 SHALL have port CLK  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port sample_in  input  DATA_W  traced bus (core OUT).
REQ-007 SHALL have port sample_en  input  1  capture enable.
REQ-008 SHALL have port clr_ovf  input  1  synchronous clear of the overflow flag.
REQ-009 SHALL have port rd_ready  input  1  consumer accepts the head entry.
REQ-010 SHALL have port rd_valid  output  1  FIFO non-empty; head entry presented.
REQ-011 SHALL have port rd_data  output  DATA_W  head entry sample value.
REQ-012 SHALL have port rd_ts  output  TS_W  head entry timestamp.
REQ-013 SHALL have port count  output  clog2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-014 SHALL have port overflow  output  1  sticky flag: at least one entry dropped.

Function
REQ-015 SHALL keep a free-running TS_W-bit counter ts_q that increments every cycle and wraps from 2^TS_W-1 to 0.
REQ-016 SHALL keep last_q (last captured value) and arm_q (first-capture pending) registers.
REQ-017 SHALL raise push when sample_en=1 and (arm_q=1 or sample_in != last_q).
REQ-018 On push SHALL write {ts_q, sample_in} to the tail, set last_q=sample_in, and clear arm_q.
REQ-019 SHALL set arm_q=1 in any cycle with sample_en=0, so the first enabled cycle always captures.
REQ-020 SHALL be show-ahead: rd_valid=(count!=0); rd_data and rd_ts reflect the head entry combinationally from storage.
REQ-021 SHALL pop when rd_valid=1 and rd_ready=1; rd_ready while empty has no effect.
REQ-022 SHALL give one-cycle latency: a push at edge k asserts rd_valid after edge k when the FIFO was empty.
REQ-023 With push and pop in the same cycle SHALL leave count unchanged, including when full or holding one entry.
REQ-024 With push while full and no pop SHALL drop the sample, set overflow, leave last_q and arm_q unchanged, and leave count at DEPTH.
REQ-025 SHALL clear overflow on clr_ovf=1, except in a cycle that also drops, where set wins.
REQ-026 SHALL wrap head and tail pointers modulo DEPTH without loss or duplication.

Reset
REQ-027 reset_n=0 SHALL asynchronously force ts_q=0, last_q=0, arm_q=1, head=tail=0, count=0, overflow=0, rd_valid=0.
REQ-028 Reset mid-operation SHALL discard all stored entries; storage contents need no reset.
REQ-029 On reset deassertion SHALL resume at the next rising edge with ts_q counting from 0.

Configuration
REQ-030 Macro OUT_TRACE_TS_EN defined: timestamp counter and per-entry TS storage present; rd_ts as specified.
REQ-031 Macro OUT_TRACE_TS_EN undefined: no counter and no TS storage; rd_ts tied to 0; all other behaviour identical.

Verification
REQ-032 Reset, then sample_en=1 with sample_in held at 10'h005 for 8 cycles -> exactly one entry, rd_data=10'h005, rd_ts equals the ts at the first enabled edge.
REQ-033 sample_in steps 1,2,3 on consecutive cycles with rd_ready=0 -> count=3, then pops return 1,2,3 with consecutive timestamps.
REQ-034 DEPTH=16, 20 distinct changes with rd_ready=0 -> count=16, overflow=1, entries 1..16 retained; clr_ovf pulse -> overflow=0.
REQ-035 Full FIFO with push and pop in the same cycle -> count stays 16, overflow stays 0, oldest entry removed.
REQ-036 reset_n low for 3 ns mid-stream with 5 entries stored -> rd_valid=0 and count=0 immediately; first enabled sample after release is captured.
REQ-037 Build without OUT_TRACE_TS_EN and rerun REQ-033 -> same data order, rd_ts=0 on every entry.
